// File: rtl/arrow_input_conditioner.sv
// Arrow-key front end: per-key 2-FF sync and debounce, opposite-direction cancel,
// and outputs that load only on clk_char falls so the movement stage samples clean levels.
module arrow_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHAR_DIV        = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    output logic       u_arr,
    output logic       d_arr,
    output logic       l_arr,
    output logic       r_arr,
    output logic       clk_char,
    output logic [3:0] press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int DW = $clog2(CHAR_DIV);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CHAR_DIV - 1);

    // Key vectors are ordered {right, left, down, up}, all active-low.
    logic [3:0]    raw_keys;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    state_q, state_d;
    logic [3:0]    state_dly_q;
    logic [3:0]    pulse_q;
    logic [CW-1:0] db_cnt_q [4];
    logic [CW-1:0] db_cnt_d [4];
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          clk_char_q;
    logic          div_wrap;
    logic          char_fall;
    logic [3:0]    cancelled;
    logic [3:0]    arr_q, arr_d;

    assign raw_keys = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        for (int k = 0; k < 4; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (sync2_q[k] == state_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DB_MAX) begin
                state_d[k]  = sync2_q[k];
                db_cnt_d[k] = '0;
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + CW'(1);
            end
        end
    end

    // Opposite pairs pressed together cancel to "released".
    always_comb begin
        cancelled = state_q;
        if (!state_q[0] && !state_q[1]) cancelled[1:0] = 2'b11;
        if (!state_q[2] && !state_q[3]) cancelled[3:2] = 2'b11;
    end

    assign div_wrap  = (div_cnt_q == DIV_MAX);
    assign div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
    assign char_fall = div_wrap && clk_char_q;
    assign arr_d     = char_fall ? cancelled : arr_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            state_q     <= 4'hF;
            state_dly_q <= 4'hF;
            pulse_q     <= 4'h0;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
            div_cnt_q   <= '0;
            clk_char_q  <= 1'b0;
            arr_q       <= 4'hF;
        end else begin
            sync1_q     <= raw_keys;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            state_dly_q <= state_q;
            pulse_q     <= state_dly_q & ~state_q;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= db_cnt_d[k];
            div_cnt_q   <= div_cnt_d;
            if (div_wrap) clk_char_q <= ~clk_char_q;
            arr_q       <= arr_d;
        end
    end

    assign u_arr       = arr_q[0];
    assign d_arr       = arr_q[1];
    assign l_arr       = arr_q[2];
    assign r_arr       = arr_q[3];
    assign clk_char    = clk_char_q;
    assign press_pulse = pulse_q;

endmodule
